scan_test_controller: RTL and testbench

Sequencer that drives one scan chain through complete test cycles: serial load of a stimulus pattern, one functional capture clock, and serial unload of the response. For each pattern it compares the response against an expected value under a mask. It sits between a pattern source (ATE/BIST front end) and the chain's `scan_en` / `scan_in` / scan-out pins, and replaces hand-driven `scan_en` toggling.

---
 rtl/scan_test_controller_if.sv | 40 ++++
 rtl/scan_test_controller.sv | 216 +++++++++++++++++++++
 tb/tb_scan_test_controller.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_test_controller_if.sv
// -----------------------------------------------------------------------------
// scan_test_controller_if
//
// Pattern/response channel between a pattern source (ATE or BIST front end)
// and scan_test_controller.
//
//   start_valid / start_ready : pattern request handshake
//   pat_data                  : stimulus, bit 0 shifted first
//   exp_data / exp_mask       : expected response and compare mask (1 = compare)
//   abort                     : drop the pattern currently in flight
//   resp_valid / resp_ready   : response handshake
//   resp_data                 : unloaded response, bit 0 is the first bit out
//   fail                      : masked mismatch flag, valid with resp_valid
//
// master = pattern source, slave = controller.
// -----------------------------------------------------------------------------
interface scan_test_controller_if #(
    parameter int CHAIN_LEN = 4
);
    logic                 start_valid;
    logic                 start_ready;
    logic [CHAIN_LEN-1:0] pat_data;
    logic [CHAIN_LEN-1:0] exp_data;
    logic [CHAIN_LEN-1:0] exp_mask;
    logic                 abort;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [CHAIN_LEN-1:0] resp_data;
    logic                 fail;

    modport master (
        output start_valid, pat_data, exp_data, exp_mask, abort, resp_ready,
        input  start_ready, resp_valid, resp_data, fail
    );

    modport slave (
        input  start_valid, pat_data, exp_data, exp_mask, abort, resp_ready,
        output start_ready, resp_valid, resp_data, fail
    );
endinterface

// File: rtl/scan_test_controller.sv
// -----------------------------------------------------------------------------
// scan_test_controller
//
// Drives one scan chain through complete test cycles: serial load of a
// stimulus pattern, one functional capture edge, serial unload of the
// response, then a masked compare against the expected value.
//
// Ports:
//   clk        : single rising-edge clock shared with the chain flops
//   rst_n      : asynchronous active-low reset
//   bus        : pattern/response channel (slave side)
//   chain_so   : scan-out of the chain's last flop
//   scan_en    : registered chain scan enable
//   scan_in    : registered chain serial input
//   busy       : controller is not idle
//   pat_count  : completed response handshakes (saturating)
//   fail_count : completed handshakes that reported fail (saturating)
// -----------------------------------------------------------------------------
module scan_test_controller #(
    parameter int   CHAIN_LEN = 4,
    parameter logic FILL_BIT  = 1'b0,
    parameter int   CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scan_test_controller_if.slave bus,
    input  logic                  chain_so,
    output logic                  scan_en,
    output logic                  scan_in,
    output logic                  busy,
    output logic [CNT_W-1:0]      pat_count,
    output logic [CNT_W-1:0]      fail_count
);

    localparam int                CW   = $clog2(CHAIN_LEN);
    localparam logic [CW-1:0]     LAST = CW'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CMAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CHAIN_LEN-1:0] pat_sh_q, pat_sh_d;      // stimulus, consumed LSB first
    logic [CHAIN_LEN-1:0] exp_q, exp_d;
    logic [CHAIN_LEN-1:0] mask_q, mask_d;
    logic [CHAIN_LEN-1:0] resp_sh_q, resp_sh_d;    // response being assembled
    logic [CHAIN_LEN-1:0] resp_data_q, resp_data_d;
    logic                 scan_en_q, scan_en_d;
    logic                 scan_in_q, scan_in_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 fail_q, fail_d;
    logic [CNT_W-1:0]     pat_count_q, pat_count_d;
    logic [CNT_W-1:0]     fail_count_q, fail_count_d;

    logic                 aborting;
    logic                 handshake;
    logic [CHAIN_LEN-1:0] resp_next;

    // Abort only matters while the chain is being driven; IDLE and DONE ignore it.
    assign aborting  = bus.abort &&
                       (state_q == S_SHIFT || state_q == S_CAPTURE || state_q == S_UNLOAD);
    assign handshake = (state_q == S_DONE) && bus.resp_ready;

    // The first bit out enters at the MSB and walks down to bit 0 after N shifts.
    assign resp_next = {chain_so, resp_sh_q[CHAIN_LEN-1:1]};

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are small flop vectors, not a RAM array, so resetting
            // every one of them is cheap and keeps outputs defined after reset.
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pat_sh_q     <= '0;
            exp_q        <= '0;
            mask_q       <= '0;
            resp_sh_q    <= '0;
            resp_data_q  <= '0;
            scan_en_q    <= 1'b0;
            scan_in_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            fail_q       <= 1'b0;
            pat_count_q  <= '0;
            fail_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pat_sh_q     <= pat_sh_d;
            exp_q        <= exp_d;
            mask_q       <= mask_d;
            resp_sh_q    <= resp_sh_d;
            resp_data_q  <= resp_data_d;
            scan_en_q    <= scan_en_d;
            scan_in_q    <= scan_in_d;
            resp_valid_q <= resp_valid_d;
            fail_q       <= fail_d;
            pat_count_q  <= pat_count_d;
            fail_count_q <= fail_count_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        if (aborting) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (bus.start_valid) state_d = S_SHIFT;
                S_SHIFT:   if (cnt_q == LAST)   state_d = S_CAPTURE;
                S_CAPTURE:                      state_d = S_UNLOAD;
                S_UNLOAD:  if (cnt_q == LAST)   state_d = S_DONE;
                S_DONE:    if (handshake)       state_d = S_IDLE;
                default:                        state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------ outputs / datapath
    always_comb begin
        cnt_d        = cnt_q;
        pat_sh_d     = pat_sh_q;
        exp_d        = exp_q;
        mask_d       = mask_q;
        resp_sh_d    = resp_sh_q;
        resp_data_d  = resp_data_q;
        scan_en_d    = scan_en_q;
        scan_in_d    = scan_in_q;
        resp_valid_d = resp_valid_q;
        fail_d       = fail_q;
        pat_count_d  = pat_count_q;
        fail_count_d = fail_count_q;

        if (aborting) begin
            scan_en_d = 1'b0;
            scan_in_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    scan_en_d = 1'b0;
                    scan_in_d = 1'b0;
                    if (bus.start_valid) begin
                        pat_sh_d  = bus.pat_data;
                        exp_d     = bus.exp_data;
                        mask_d    = bus.exp_mask;
                        scan_en_d = 1'b1;
                        scan_in_d = bus.pat_data[0];
                        cnt_d     = '0;
                    end
                end
                S_SHIFT: begin
                    // The chain takes the current bit this edge; present the next.
                    scan_in_d = pat_sh_q[1];
                    pat_sh_d  = pat_sh_q >> 1;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        scan_en_d = 1'b0;
                        scan_in_d = 1'b0;
                        cnt_d     = '0;
                    end
                end
                S_CAPTURE: begin
                    scan_en_d = 1'b1;
                    scan_in_d = FILL_BIT;
                    cnt_d     = '0;
                end
                S_UNLOAD: begin
                    // chain_so still shows the pre-shift bit at this edge.
                    resp_sh_d = resp_next;
                    cnt_d     = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        scan_en_d    = 1'b0;
                        scan_in_d    = 1'b0;
                        cnt_d        = '0;
                        resp_data_d  = resp_next;
                        fail_d       = |((resp_next ^ exp_q) & mask_q);
                        resp_valid_d = 1'b1;
                    end
                end
                S_DONE: begin
                    if (handshake) begin
                        resp_valid_d = 1'b0;
                        if (pat_count_q != CMAX)
                            pat_count_d = pat_count_q + CNT_W'(1);
                        if (fail_q && fail_count_q != CMAX)
                            fail_count_d = fail_count_q + CNT_W'(1);
                    end
                end
                default: begin
                    scan_en_d = 1'b0;
                    scan_in_d = 1'b0;
                end
            endcase
        end
    end

    assign bus.start_ready = (state_q == S_IDLE);
    assign busy            = (state_q != S_IDLE);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_data   = resp_data_q;
    assign bus.fail        = fail_q;
    assign scan_en         = scan_en_q;
    assign scan_in         = scan_in_q;
    assign pat_count       = pat_count_q;
    assign fail_count      = fail_count_q;

endmodule

// File: tb/tb_scan_test_controller.sv
// -----------------------------------------------------------------------------
// tb_scan_test_controller
//
// Self-checking bench for scan_test_controller with CHAIN_LEN = 4. A
// behavioural chain (shift on scan_en, capture ~q otherwise) sits on the scan
// pins. Expected responses come from a chain-level model: after load, pattern
// bit k sits in flop N-1-k; capture inverts; unload reads the last flop first.
// -----------------------------------------------------------------------------
module tb_scan_test_controller;

    localparam int N     = 4;
    localparam int CNT_W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    scan_test_controller_if #(.CHAIN_LEN(N)) bus ();

    logic             chain_so;
    logic             scan_en;
    logic             scan_in;
    logic             busy;
    logic [CNT_W-1:0] pat_count;
    logic [CNT_W-1:0] fail_count;

    scan_test_controller #(
        .CHAIN_LEN (N),
        .FILL_BIT  (1'b0),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .chain_so   (chain_so),
        .scan_en    (scan_en),
        .scan_in    (scan_in),
        .busy       (busy),
        .pat_count  (pat_count),
        .fail_count (fail_count)
    );

    // Behavioural scan chain: flop 0 takes scan_in, flop N-1 drives chain_so.
    logic [N-1:0] chain_q = '0;
    always @(posedge clk) begin
        if (scan_en) chain_q <= {chain_q[N-2:0], scan_in};
        else         chain_q <= ~chain_q;
    end
    assign chain_so = chain_q[N-1];

    int n_cmp  = 0;
    int n_err  = 0;
    int m_pat  = 0;
    int m_fail = 0;

    function automatic logic [N-1:0] model_resp(input logic [N-1:0] pat);
        logic [N-1:0] flops;
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) flops[N-1-k] = pat[k];
        flops = ~flops;
        for (int k = 0; k < N; k++) r[k] = flops[N-1-k];
        return r;
    endfunction

    // Runs one full pattern starting from IDLE at a falling edge. ready_wait
    // cycles of backpressure are applied in DONE, with start_valid (and
    // optionally abort) asserted to show they are ignored there.
    task automatic run_pattern(input logic [N-1:0] pat, input logic [N-1:0] expv,
                               input logic [N-1:0] mask, input int ready_wait,
                               input logic abort_in_done, input string tag);
        logic [N-1:0] want_resp;
        logic         want_fail;
        int           lat;
        want_resp = model_resp(pat);
        want_fail = |((want_resp ^ expv) & mask);

        n_cmp++;
        if (bus.start_ready !== 1'b1) begin
            n_err++; $display("FAIL %s start_ready idle: got %b want 1", tag, bus.start_ready);
        end
        bus.start_valid = 1'b1;
        bus.pat_data    = pat;
        bus.exp_data    = expv;
        bus.exp_mask    = mask;
        bus.resp_ready  = 1'b0;
        @(negedge clk);
        bus.start_valid = 1'b0;
        bus.pat_data    = N'($urandom);
        bus.exp_data    = N'($urandom);
        bus.exp_mask    = N'($urandom);

        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if ({scan_en, scan_in} !== {1'b1, pat[j]}) begin
                n_err++;
                $display("FAIL %s shift bit %0d: got en=%b in=%b want en=1 in=%b",
                         tag, j, scan_en, scan_in, pat[j]);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (scan_en !== 1'b0) begin
            n_err++; $display("FAIL %s capture scan_en: got %b want 0", tag, scan_en);
        end

        lat = N;
        while (bus.resp_valid !== 1'b1 && lat < 4 * N) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat !== 2 * N + 1) begin
            n_err++; $display("FAIL %s resp_valid latency: got %0d want %0d", tag, lat, 2 * N + 1);
        end
        n_cmp++;
        if ({bus.resp_data, bus.fail} !== {want_resp, want_fail}) begin
            n_err++;
            $display("FAIL %s response: got data=%b fail=%b want data=%b fail=%b",
                     tag, bus.resp_data, bus.fail, want_resp, want_fail);
        end
        n_cmp++;
        if ({busy, bus.start_ready, scan_en} !== 3'b100) begin
            n_err++;
            $display("FAIL %s done flags: got busy=%b start_ready=%b scan_en=%b want 1 0 0",
                     tag, busy, bus.start_ready, scan_en);
        end

        for (int i = 0; i < ready_wait; i++) begin
            bus.start_valid = 1'b1;
            bus.abort       = abort_in_done;
            @(negedge clk);
            n_cmp++;
            if ({bus.resp_valid, bus.resp_data, bus.fail, bus.start_ready} !==
                {1'b1, want_resp, want_fail, 1'b0}) begin
                n_err++;
                $display("FAIL %s hold cycle %0d: got valid=%b data=%b fail=%b start_ready=%b",
                         tag, i, bus.resp_valid, bus.resp_data, bus.fail, bus.start_ready);
            end
            n_cmp++;
            if (pat_count !== CNT_W'(m_pat) || fail_count !== CNT_W'(m_fail)) begin
                n_err++;
                $display("FAIL %s hold counters: got %0d/%0d want %0d/%0d",
                         tag, pat_count, fail_count, m_pat, m_fail);
            end
        end
        bus.start_valid = 1'b0;
        bus.abort       = 1'b0;

        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        m_pat++;
        if (want_fail) m_fail++;
        n_cmp++;
        if (pat_count !== CNT_W'(m_pat) || fail_count !== CNT_W'(m_fail)) begin
            n_err++;
            $display("FAIL %s counters: got %0d/%0d want %0d/%0d",
                     tag, pat_count, fail_count, m_pat, m_fail);
        end
        n_cmp++;
        if ({bus.resp_valid, bus.start_ready, bus.resp_data} !== {1'b0, 1'b1, want_resp}) begin
            n_err++;
            $display("FAIL %s after handshake: got valid=%b start_ready=%b data=%b want 0 1 %b",
                     tag, bus.resp_valid, bus.start_ready, bus.resp_data, want_resp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_cmp++;
        if ({bus.start_ready, busy, scan_en, scan_in, bus.resp_valid, bus.fail} !== 6'b100000) begin
            n_err++;
            $display("FAIL %s flags: got rdy=%b busy=%b en=%b in=%b valid=%b fail=%b want 1 0 0 0 0 0",
                     tag, bus.start_ready, busy, scan_en, scan_in, bus.resp_valid, bus.fail);
        end
        n_cmp++;
        if (bus.resp_data !== '0) begin
            n_err++; $display("FAIL %s resp_data: got %b want 0", tag, bus.resp_data);
        end
        n_cmp++;
        if (pat_count !== '0 || fail_count !== '0) begin
            n_err++; $display("FAIL %s counters: got %0d/%0d want 0/0", tag, pat_count, fail_count);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_pattern(4'b1101, 4'b0010, 4'hF, 0, 1'b0, "basic");
    endtask

    task automatic test_mask();
        run_pattern(4'b1101, 4'b0011, 4'hF, 0, 1'b0, "mask_full");
        run_pattern(4'b1101, 4'b0011, 4'b1110, 0, 1'b0, "mask_bit0_off");
    endtask

    task automatic test_backpressure();
        run_pattern(N'($urandom), N'($urandom), N'($urandom), 10, 1'b0, "backpressure");
        run_pattern(N'($urandom), N'($urandom), 4'hF, 3, 1'b1, "abort_in_done");
    endtask

    task automatic test_abort();
        for (int t = 0; t < 5; t++) begin
            int e;
            e = (t == 0) ? 2 : (t == 1) ? 2 * N + 1 : int'($urandom_range(1, 2 * N + 1));
            bus.start_valid = 1'b1;
            bus.pat_data    = N'($urandom);
            bus.exp_data    = N'($urandom);
            bus.exp_mask    = N'($urandom);
            @(negedge clk);
            bus.start_valid = 1'b0;
            repeat (e - 1) @(negedge clk);
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
            n_cmp++;
            if ({scan_en, scan_in, busy, bus.start_ready, bus.resp_valid} !== 5'b00010) begin
                n_err++;
                $display("FAIL abort@%0d flags: got en=%b in=%b busy=%b rdy=%b valid=%b want 0 0 0 1 0",
                         e, scan_en, scan_in, busy, bus.start_ready, bus.resp_valid);
            end
            n_cmp++;
            if (pat_count !== CNT_W'(m_pat) || fail_count !== CNT_W'(m_fail)) begin
                n_err++;
                $display("FAIL abort@%0d counters: got %0d/%0d want %0d/%0d",
                         e, pat_count, fail_count, m_pat, m_fail);
            end
            repeat (3) @(negedge clk);
            n_cmp++;
            if ({busy, bus.resp_valid} !== 2'b00) begin
                n_err++;
                $display("FAIL abort@%0d settle: got busy=%b valid=%b want 0 0", e, busy, bus.resp_valid);
            end
        end
        run_pattern(N'($urandom), N'($urandom), N'($urandom), 0, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid_unload();
        bus.start_valid = 1'b1;
        bus.pat_data    = N'($urandom);
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (N + 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset_mid_unload");
        @(negedge clk);
        rst_n  = 1'b1;
        m_pat  = 0;
        m_fail = 0;
        @(negedge clk);
        run_pattern(N'($urandom), N'($urandom), N'($urandom), 1, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_pattern(N'($urandom), N'($urandom), N'($urandom),
                        int'($urandom_range(0, 3)), 1'b0, "random");
    endtask

    task automatic test_back_to_back();
        int           acc[$];
        logic [N-1:0] q_resp[$];
        logic         q_fail[$];
        logic [N-1:0] r;
        logic         wf;
        logic         accepted;
        int           hs;
        int           cyc;
        hs  = 0;
        cyc = 0;
        bus.pat_data    = N'($urandom);
        bus.exp_data    = N'($urandom);
        bus.exp_mask    = N'($urandom);
        bus.start_valid = 1'b1;
        bus.resp_ready  = 1'b1;
        while (hs < 3 && cyc < 200) begin
            accepted = 1'b0;
            if (bus.start_ready === 1'b1 && bus.start_valid) begin
                acc.push_back(cyc);
                r = model_resp(bus.pat_data);
                q_resp.push_back(r);
                q_fail.push_back(|((r ^ bus.exp_data) & bus.exp_mask));
                accepted = 1'b1;
            end
            if (bus.resp_valid === 1'b1) begin
                n_cmp++;
                if (q_resp.size() == 0) begin
                    n_err++; $display("FAIL b2b unexpected response at cycle %0d", cyc);
                end else begin
                    r  = q_resp.pop_front();
                    wf = q_fail.pop_front();
                    if ({bus.resp_data, bus.fail} !== {r, wf}) begin
                        n_err++;
                        $display("FAIL b2b response %0d: got data=%b fail=%b want data=%b fail=%b",
                                 hs, bus.resp_data, bus.fail, r, wf);
                    end
                    m_pat++;
                    if (wf) m_fail++;
                end
                hs++;
            end
            @(negedge clk);
            cyc++;
            if (accepted) begin
                bus.pat_data = N'($urandom);
                bus.exp_data = N'($urandom);
                bus.exp_mask = N'($urandom);
                if (acc.size() == 3) bus.start_valid = 1'b0;
            end
        end
        bus.start_valid = 1'b0;
        bus.resp_ready  = 1'b0;
        n_cmp++;
        if (hs !== 3) begin
            n_err++; $display("FAIL b2b handshakes: got %0d want 3 within budget", hs);
        end
        n_cmp++;
        if (acc.size() != 3) begin
            n_err++; $display("FAIL b2b accepts: got %0d want 3", acc.size());
        end else if (acc[1] - acc[0] !== 2 * N + 3 || acc[2] - acc[1] !== 2 * N + 3) begin
            n_err++;
            $display("FAIL b2b spacing: got %0d,%0d want %0d", acc[1] - acc[0], acc[2] - acc[1], 2 * N + 3);
        end
        n_cmp++;
        if (pat_count !== CNT_W'(m_pat) || fail_count !== CNT_W'(m_fail)) begin
            n_err++;
            $display("FAIL b2b counters: got %0d/%0d want %0d/%0d", pat_count, fail_count, m_pat, m_fail);
        end
    endtask

    initial begin
        bus.start_valid = 1'b0;
        bus.pat_data    = '0;
        bus.exp_data    = '0;
        bus.exp_mask    = '0;
        bus.abort       = 1'b0;
        bus.resp_ready  = 1'b0;

        test_reset();
        test_basic();
        test_mask();
        test_backpressure();
        test_abort();
        test_reset_mid_unload();
        test_random();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
